// File: rtl/alu_pipe_seq.sv
// Registered execute-stage ALU with valid/ready on both sides and an iterative shift-add MUL.
// Define ALU_MUL_EN to build the multiplier and its MUL state; otherwise op 5'h10 is Illegal.
module alu_pipe_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [4:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ofl,
  output logic             Eqz,
  output logic             Nez,
  output logic             Ltz,
  output logic             Gez,
  output logic             Busy,
  output logic             Illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ofl;
    logic             eqz;
    logic             nez;
    logic             ltz;
    logic             gez;
    logic             ill;
  } res_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  localparam logic [4:0] OP_MUL = 5'h10;

  function automatic res_t value_flags(input logic [WIDTH-1:0] v);
    res_t r;
    r     = '0;
    r.out = v;
    r.eqz = (v == '0);
    r.nez = (v != '0);
    r.ltz = v[WIDTH-1];
    r.gez = ~v[WIDTH-1];
    return r;
  endfunction

  function automatic res_t alu_f(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic        [WIDTH:0]     add_x;
    logic        [WIDTH:0]     sub_x;
    logic signed [WIDTH:0]     dif_s;
    logic        [2*WIDTH-1:0] dbl_r;
    logic        [2*WIDTH-1:0] dbl_l;
    logic        [CNT_W-1:0]   cnt;
    logic                      lt;
    logic                      eq;
    logic                      add_ofl;
    logic                      sub_ofl;
    res_t                      r;
    cnt     = b[CNT_W-1:0];
    add_x   = {1'b0, a} + {1'b0, b};
    sub_x   = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};
    // Sign of the sign-extended difference is correct even when A-B overflows WIDTH bits.
    dif_s   = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    lt      = dif_s[WIDTH];
    eq      = (a == b);
    add_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
    sub_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != b[WIDTH-1]);
    dbl_r   = {a, a} >> cnt;
    dbl_l   = {a, a} << cnt;
    r       = '0;
    if (op[4]) begin
      r.ill = 1'b1;
    end else begin
      case (op[3:0])
        4'h0: begin r = value_flags(add_x[WIDTH-1:0]); r.cout = add_x[WIDTH]; r.ofl = add_ofl; end
        4'h1: begin r = value_flags(sub_x[WIDTH-1:0]); r.cout = sub_x[WIDTH]; r.ofl = sub_ofl; end
        4'h2: r = value_flags(a ^ b);
        4'h3: r = value_flags(a & ~b);
        4'h4: r = value_flags(a << cnt);
        4'h5: r = value_flags(dbl_r[WIDTH-1:0]);
        4'h6: r = value_flags(a >> cnt);
        4'h7: r = value_flags(dbl_l[2*WIDTH-1:WIDTH]);
        4'hC: begin r.out = {{(WIDTH-1){1'b0}}, add_x[WIDTH]}; r.cout = add_x[WIDTH]; r.ofl = add_ofl; end
        4'hD: r.out = {{(WIDTH-1){1'b0}}, eq};
        4'hE: r.out = {{(WIDTH-1){1'b0}}, lt};
        4'hF: r.out = {{(WIDTH-1){1'b0}}, lt | eq};
        default: r.out = '0;
      endcase
      if (op[3]) begin
        r.eqz = (a == '0);
        r.nez = (a != '0);
        r.ltz = a[WIDTH-1];
        r.gez = ~a[WIDTH-1];
      end
    end
    return r;
  endfunction

  state_t state_q, state_d;
  res_t   res_q, res_d;
  logic   vld_q, vld_d;
  logic   accept;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign In_ready = (state_q == S_IDLE) && (!vld_q || Out_ready);
  assign accept   = In_valid && In_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    vld_d   = vld_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (vld_q && Out_ready) vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (Op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else
`endif
          begin
            res_d = alu_f(Op, A, B);
            vld_d = 1'b1;
          end
        end else if (vld_q && !Out_ready) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (Out_ready) state_d = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL: begin
        // One multiplier bit per cycle; the final partial sum goes straight to the output register.
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          res_d   = value_flags(acc_nx);
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ALU_MUL_EN
  // Multiplier working registers are reloaded on every MUL accept, so they need no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
  end
  assign Busy = (state_q == S_MUL);
`else
  assign Busy = 1'b0;
`endif

  assign Out_valid = vld_q;
  assign Out       = res_q.out;
  assign Cout      = res_q.cout;
  assign Ofl       = res_q.ofl;
  assign Eqz       = res_q.eqz;
  assign Nez       = res_q.nez;
  assign Ltz       = res_q.ltz;
  assign Gez       = res_q.gez;
  assign Illegal   = res_q.ill;

endmodule
